// File: rtl/alu_operand_sequencer_if.sv
// Board-side and ALU-side signal bundle for alu_operand_sequencer.
// The master modport is the sequencer; the slave modport is the board/ALU side.
interface alu_operand_sequencer_if #(
    parameter int N = 8
);
    logic [N-1:0] sw;
    logic [3:0]   sel_sw;
    logic         cin_sw;
    logic         btn_next;
    logic         btn_clear;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic         alu_cin;

    logic [N-1:0] alu_result;
    logic         alu_neg;
    logic         alu_zero;
    logic         alu_cout;
    logic         alu_ovf;

    logic [N-1:0] res_q;
    logic [3:0]   flags_q;
    logic         valid;
    logic [2:0]   state_o;

    modport master (
        input  sw, sel_sw, cin_sw, btn_next, btn_clear,
        input  alu_result, alu_neg, alu_zero, alu_cout, alu_ovf,
        output alu_a, alu_b, alu_sel, alu_cin,
        output res_q, flags_q, valid, state_o
    );

    modport slave (
        output sw, sel_sw, cin_sw, btn_next, btn_clear,
        output alu_result, alu_neg, alu_zero, alu_cout, alu_ovf,
        input  alu_a, alu_b, alu_sel, alu_cin,
        input  res_q, flags_q, valid, state_o
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Button-driven operand/opcode capture and result holding for the lab ALU.
// Optional button debouncing is compiled in with ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_operand_sequencer_if.master bus
);
    localparam logic [2:0] S_LOAD_A  = 3'd0;
    localparam logic [2:0] S_LOAD_B  = 3'd1;
    localparam logic [2:0] S_LOAD_OP = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_SHOW    = 3'd4;

    // Index 0 is btn_next, index 1 is btn_clear.
    logic [1:0] w_btn_raw;
    logic [1:0] w_btn_sync;
    logic [1:0] w_btn_lvl;

    assign w_btn_raw = {bus.btn_clear, bus.btn_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic r_sync1;
            logic r_sync2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end
            assign w_btn_sync[gi] = r_sync2;
        end
    endgenerate

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            logic          r_level;
            logic [CW-1:0] r_cnt;
            // Any sample that agrees with the accepted level restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else if (w_btn_sync[gi] != r_level) begin
                    if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_level <= w_btn_sync[gi];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
            assign w_btn_lvl[gi] = r_level;
        end
    endgenerate
`else
    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_unused
        end
        for (gi = 0; gi < 2; gi++) begin : g_passthru
            assign w_btn_lvl[gi] = w_btn_sync[gi];
        end
    endgenerate
`endif

    logic r_next_prev;
    logic w_press;
    logic w_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_prev <= 1'b0;
        end else begin
            r_next_prev <= w_btn_lvl[0];
        end
    end

    assign w_press = w_btn_lvl[0] & ~r_next_prev;
    assign w_clear = w_btn_lvl[1];

    logic [2:0] r_state;
    logic [2:0] w_state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = S_LOAD_A;
        end else begin
            case (r_state)
                S_LOAD_A:  if (w_press) w_state_next = S_LOAD_B;
                S_LOAD_B:  if (w_press) w_state_next = S_LOAD_OP;
                S_LOAD_OP: if (w_press) w_state_next = S_EXEC;
                S_EXEC:    w_state_next = S_SHOW;
                S_SHOW:    if (w_press) w_state_next = S_LOAD_A;
                default:   w_state_next = S_LOAD_A;
            endcase
        end
    end

    logic w_ld_a;
    logic w_ld_b;
    logic w_ld_op;
    logic w_exec;
    logic w_drop_valid;

    always_comb begin
        w_ld_a       = 1'b0;
        w_ld_b       = 1'b0;
        w_ld_op      = 1'b0;
        w_exec       = 1'b0;
        w_drop_valid = 1'b0;
        case (r_state)
            S_LOAD_A:  w_ld_a       = w_press;
            S_LOAD_B:  w_ld_b       = w_press;
            S_LOAD_OP: w_ld_op      = w_press;
            S_EXEC:    w_exec       = 1'b1;
            S_SHOW:    w_drop_valid = w_press;
            default:   ;
        endcase
    end

    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [3:0]   r_alu_sel;
    logic         r_alu_cin;
    logic [N-1:0] r_res;
    logic [3:0]   r_flags;
    logic         r_valid;

    // Clear outranks every load enable, so a coincident press captures nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_alu_cin <= 1'b0;
            r_res     <= '0;
            r_flags   <= '0;
            r_valid   <= 1'b0;
        end else if (w_clear) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_alu_cin <= 1'b0;
            r_res     <= '0;
            r_flags   <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (w_ld_a) r_alu_a <= bus.sw;
            if (w_ld_b) r_alu_b <= bus.sw;
            if (w_ld_op) begin
                r_alu_sel <= bus.sel_sw;
                r_alu_cin <= bus.cin_sw;
            end
            if (w_exec) begin
                r_res   <= bus.alu_result;
                r_flags <= {bus.alu_neg, bus.alu_zero, bus.alu_cout, bus.alu_ovf};
                r_valid <= 1'b1;
            end else if (w_drop_valid) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_a   = r_alu_a;
    assign bus.alu_b   = r_alu_b;
    assign bus.alu_sel = r_alu_sel;
    assign bus.alu_cin = r_alu_cin;
    assign bus.res_q   = r_res;
    assign bus.flags_q = r_flags;
    assign bus.valid   = r_valid;
    assign bus.state_o = r_state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small combinational ALU model.
module tb_alu_operand_sequencer;
    localparam int N = 8;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer_if #(.N(N)) bus ();

    alu_operand_sequencer #(
        .N(N),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    // ALU model: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5-9 NOT A, 10-15 invalid.
    logic [N:0]   m_sum;
    logic [N-1:0] m_res;
    always_comb begin
        m_sum = '0;
        m_res = '0;
        bus.alu_cout = 1'b0;
        bus.alu_ovf  = 1'b0;
        case (bus.alu_sel)
            4'd0: begin
                m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{N{1'b0}}, bus.alu_cin};
                m_res = m_sum[N-1:0];
                bus.alu_cout = m_sum[N];
                bus.alu_ovf  = (bus.alu_a[N-1] == bus.alu_b[N-1]) && (m_res[N-1] != bus.alu_a[N-1]);
            end
            4'd1: begin
                m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{N{1'b0}}, 1'b1};
                m_res = m_sum[N-1:0];
                bus.alu_cout = m_sum[N];
                bus.alu_ovf  = (bus.alu_a[N-1] != bus.alu_b[N-1]) && (m_res[N-1] != bus.alu_a[N-1]);
            end
            4'd2: m_res = bus.alu_a | bus.alu_b;
            4'd3: m_res = bus.alu_a & bus.alu_b;
            4'd4: m_res = bus.alu_a ^ bus.alu_b;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: m_res = ~bus.alu_a;
            default: m_res = '0;
        endcase
        bus.alu_result = m_res;
        bus.alu_neg    = (bus.alu_sel <= 4'd9) ? m_res[N-1] : 1'b0;
        bus.alu_zero   = (m_res == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press();
        @(negedge clk);
        bus.btn_next = 1'b1;
        repeat (DB + 4) @(negedge clk);
        bus.btn_next = 1'b0;
        repeat (DB + 4) @(negedge clk);
        $display("press: state=%0d a=%02h b=%02h sel=%0h res=%02h flags=%04b valid=%0b",
                 bus.state_o, bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_q, bus.flags_q, bus.valid);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [3:0] sel, input logic cin);
        bus.sw = a;
        press();
        bus.sw = b;
        press();
        bus.sel_sw = sel;
        bus.cin_sw = cin;
        press();
        bus.sw = 8'hA5;
        bus.sel_sw = 4'h7;
    endtask

    initial begin
        bus.sw = '0;
        bus.sel_sw = '0;
        bus.cin_sw = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_clear = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_held_state", 32'(bus.state_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_alu_a", 32'(bus.alu_a), 32'h0);
        check("rst_alu_b", 32'(bus.alu_b), 32'h0);
        check("rst_alu_sel", 32'(bus.alu_sel), 32'h0);
        check("rst_alu_cin", 32'(bus.alu_cin), 32'h0);
        check("rst_res", 32'(bus.res_q), 32'h0);
        check("rst_flags", 32'(bus.flags_q), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_state", 32'(bus.state_o), 32'd0);

        // Press latency: action lands on the third edge after the raw rise.
        bus.sw = 8'h05;
`ifndef ALU_SEQ_DEBOUNCE_EN
        @(negedge clk);
        bus.btn_next = 1'b1;
        @(negedge clk);
        check("lat_edge1", 32'(bus.state_o), 32'd0);
        @(negedge clk);
        check("lat_edge2", 32'(bus.state_o), 32'd0);
        @(negedge clk);
        check("lat_edge3", 32'(bus.state_o), 32'd1);
        bus.btn_next = 1'b0;
        repeat (4) @(negedge clk);
`else
        press();
`endif
        check("loada_a", 32'(bus.alu_a), 32'h05);
        bus.sw = 8'h03;
        press();
        check("loadb_b", 32'(bus.alu_b), 32'h03);
        check("loadb_state", 32'(bus.state_o), 32'd2);
        bus.sel_sw = 4'd0;
        bus.cin_sw = 1'b0;
        press();
        check("add_a", 32'(bus.alu_a), 32'h05);
        check("add_b", 32'(bus.alu_b), 32'h03);
        check("add_sel", 32'(bus.alu_sel), 32'h0);
        check("add_res", 32'(bus.res_q), 32'h08);
        check("add_flags", 32'(bus.flags_q), 32'b0000);
        check("add_valid", 32'(bus.valid), 32'd1);
        check("add_state", 32'(bus.state_o), 32'd4);

        press();
        check("show_exit_valid", 32'(bus.valid), 32'd0);
        check("show_exit_state", 32'(bus.state_o), 32'd0);
        check("show_exit_res_held", 32'(bus.res_q), 32'h08);
        check("show_exit_a_held", 32'(bus.alu_a), 32'h05);

        run_op(8'hF0, 8'h0F, 4'd3, 1'b0);
        check("and_res", 32'(bus.res_q), 32'h00);
        check("and_flags", 32'(bus.flags_q), 32'b0100);
        check("and_valid", 32'(bus.valid), 32'd1);
        press();

        run_op(8'hFF, 8'h01, 4'd0, 1'b1);
        check("addc_res", 32'(bus.res_q), 32'h01);
        check("addc_flags", 32'(bus.flags_q), 32'b0010);
        check("addc_cin", 32'(bus.alu_cin), 32'd1);
        press();

        run_op(8'h12, 8'h34, 4'hC, 1'b0);
        check("inv_sel", 32'(bus.alu_sel), 32'hC);
        check("inv_res", 32'(bus.res_q), 32'h00);
        check("inv_flags", 32'(bus.flags_q), 32'b0100);
        press();

        // One long hold must advance exactly once.
        bus.sw = 8'h77;
        @(negedge clk);
        bus.btn_next = 1'b1;
        repeat (20 + DB) @(negedge clk);
        check("hold_state", 32'(bus.state_o), 32'd1);
        check("hold_a", 32'(bus.alu_a), 32'h77);
        bus.btn_next = 1'b0;
        repeat (DB + 4) @(negedge clk);
        bus.sw = 8'h99;
        repeat (5) @(negedge clk);
        check("noprs_b_held", 32'(bus.alu_b), 32'h34);
        check("noprs_state", 32'(bus.state_o), 32'd1);

        // Clear and press reach the FSM on the same edge.
        bus.sw = 8'h55;
        @(negedge clk);
        bus.btn_next = 1'b1;
        bus.btn_clear = 1'b1;
        repeat (1 + DB) @(negedge clk);
        bus.btn_clear = 1'b0;
        repeat (DB + 4) @(negedge clk);
        bus.btn_next = 1'b0;
        repeat (DB + 4) @(negedge clk);
        check("clr_state", 32'(bus.state_o), 32'd0);
        check("clr_a", 32'(bus.alu_a), 32'h0);
        check("clr_b", 32'(bus.alu_b), 32'h0);
        check("clr_sel", 32'(bus.alu_sel), 32'h0);
        check("clr_flags", 32'(bus.flags_q), 32'h0);

        // Asynchronous reset in LOAD_OP, sampled between clock edges.
        bus.sw = 8'h11;
        press();
        bus.sw = 8'h22;
        press();
        check("arst_pre_state", 32'(bus.state_o), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(bus.state_o), 32'd0);
        check("arst_a", 32'(bus.alu_a), 32'h0);
        check("arst_b", 32'(bus.alu_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef ALU_SEQ_DEBOUNCE_EN
        for (int i = 0; i < 4; i++) begin
            bus.btn_next = 1'b1;
            repeat (3) @(negedge clk);
            bus.btn_next = 1'b0;
            repeat (3) @(negedge clk);
        end
        bus.btn_next = 1'b1;
        repeat (10) @(negedge clk);
        check("db_edge10", 32'(bus.state_o), 32'd0);
        @(negedge clk);
        check("db_edge11", 32'(bus.state_o), 32'd1);
        repeat (20) @(negedge clk);
        check("db_single", 32'(bus.state_o), 32'd1);
        bus.btn_next = 1'b0;
        repeat (DB + 4) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
